// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of a single-port data memory.
// Runs one transaction at a time: IDLE (grant) -> ACCESS (drive memory) -> DONE (ack).
module dmem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned READ_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_rdata_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic [AW-1:0] mem_address_o,
    output logic [DW-1:0] mem_write_data_o,
    output logic          mem_write_o,
    output logic          mem_read_o,
    input  logic [DW-1:0] mem_read_data_i,
    output logic          busy_o,
    output logic          gnt_o
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    localparam logic [3:0] CntInit = 4'(READ_LAT - 1);

    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic          we_q, we_d;
    logic          last_grant_q, last_grant_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          pick;
    logic          in_done;

    // On a tie the port that did not win last time takes the grant.
    assign pick = (m0_req_i && m1_req_i) ? ~last_grant_q : m1_req_i;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        last_grant_d = last_grant_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (m0_req_i || m1_req_i) begin
                    sel_d   = pick;
                    we_d    = pick ? m1_we_i : m0_we_i;
                    addr_d  = pick ? m1_addr_i : m0_addr_i;
                    wdata_d = pick ? m1_wdata_i : m0_wdata_i;
                    cnt_d   = CntInit;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (we_q || cnt_q == 4'd0) begin
                    rdata_d = we_q ? '0 : mem_read_data_i;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                last_grant_d = sel_q;
                if (sel_q) begin
                    m1_rdata_d = rdata_q;
                end else begin
                    m0_rdata_d = rdata_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    // Memory strobes come straight from the state so a reset drops them at once.
    always_comb begin
        mem_address_o    = '0;
        mem_write_data_o = '0;
        mem_write_o      = 1'b0;
        mem_read_o       = 1'b0;
        if (state_q == StAccess) begin
            mem_address_o    = addr_q;
            mem_write_data_o = we_q ? wdata_q : '0;
            mem_write_o      = we_q;
            mem_read_o       = ~we_q;
        end
    end

    assign in_done    = (state_q == StDone);
    assign m0_ack_o   = in_done & ~sel_q;
    assign m1_ack_o   = in_done & sel_q;
    assign m0_rdata_o = m0_ack_o ? rdata_q : m0_rdata_q;
    assign m1_rdata_o = m1_ack_o ? rdata_q : m1_rdata_q;
    assign busy_o     = (state_q != StIdle);
    assign gnt_o      = sel_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one instance with READ_LAT=1 and one with READ_LAT=3, each driven by
// directed and randomized request rounds and checked through a transaction-level scoreboard.
module tb_dmem_arbiter;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          cyc;
    } txn_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   done [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned RL = (g == 0) ? 1 : 3;

        logic        rst_n = 1'b1;
        logic [1:0]  req;
        logic [1:0]  we;
        logic [1:0]  ack;
        logic [31:0] addr [2];
        logic [31:0] wdata [2];
        logic [31:0] rdata [2];
        logic [31:0] mem_addr, mem_wdata, mem_rdata;
        logic        mem_wr, mem_rd, busy, gnt;

        // Stand-in for Data_memory: read data is only correct after RL cycles of MemRead.
        logic [31:0] mem [16] = '{default: '0};
        logic [3:0]  rd_run = 4'd0;

        txn_t        exp_q [$];
        logic [31:0] ref_mem [16] = '{default: '0};
        logic [31:0] last_rd [2];
        bit          lg;
        bit          allow_orphan;
        int          acc_cnt;
        bit          tw [2][4];
        logic [31:0] ta [2][4];
        logic [31:0] td [2][4];

        dmem_arbiter #(
            .AW       (32),
            .DW       (32),
            .READ_LAT (RL)
        ) u_dut (
            .clk_i            (clk),
            .rst_ni           (rst_n),
            .m0_req_i         (req[0]),
            .m0_we_i          (we[0]),
            .m0_addr_i        (addr[0]),
            .m0_wdata_i       (wdata[0]),
            .m0_ack_o         (ack[0]),
            .m0_rdata_o       (rdata[0]),
            .m1_req_i         (req[1]),
            .m1_we_i          (we[1]),
            .m1_addr_i        (addr[1]),
            .m1_wdata_i       (wdata[1]),
            .m1_ack_o         (ack[1]),
            .m1_rdata_o       (rdata[1]),
            .mem_address_o    (mem_addr),
            .mem_write_data_o (mem_wdata),
            .mem_write_o      (mem_wr),
            .mem_read_o       (mem_rd),
            .mem_read_data_i  (mem_rdata),
            .busy_o           (busy),
            .gnt_o            (gnt)
        );

        always @(posedge clk) begin
            if (mem_wr) mem[mem_addr[3:0]] <= mem_wdata;
            rd_run <= mem_rd ? rd_run + 4'd1 : 4'd0;
        end
        assign mem_rdata = (mem_rd && rd_run == 4'(RL - 1)) ? mem[mem_addr[3:0]]
                                                           : {28'hDEADBEE, rd_run};

        // Monitor: memory-side checks against the head of the queue, pop on every ack.
        always @(negedge clk) begin
            if (!rst_n) begin
                acc_cnt = 0;
            end else begin
                if (mem_wr || mem_rd) begin
                    if (exp_q.size() > 0) begin
                        chk("mem_write", 32'(mem_wr), 32'(exp_q[0].we));
                        chk("mem_read", 32'(mem_rd), 32'(!exp_q[0].we));
                        chk("mem_address", mem_addr, exp_q[0].addr);
                        chk("mem_write_data", mem_wdata, exp_q[0].wdata);
                    end else if (!allow_orphan) begin
                        chk("orphan_access", 32'(mem_wr | mem_rd), 32'd0);
                    end
                    acc_cnt++;
                end
                if (ack != 2'b00) begin
                    chk("single_ack", 32'(ack == 2'b11), 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", 32'(ack), 32'd0);
                    end else begin
                        txn_t e;
                        e = exp_q.pop_front();
                        chk("ack_port", 32'(ack[1]), 32'(e.port));
                        chk("ack_cycle", cyc, e.cyc);
                        chk("ack_rdata", rdata[e.port], e.rdata);
                        chk("gnt", 32'(gnt), 32'(e.port));
                        chk("busy_in_done", 32'(busy), 32'd1);
                        chk("access_cycles", acc_cnt, e.we ? 32'd1 : 32'(RL));
                        last_rd[e.port] = e.rdata;
                        acc_cnt = 0;
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    if (!ack[p]) chk("rdata_hold", rdata[p], last_rd[p]);
                end
            end
        end

        task automatic set_txn(input int p, input int k, input bit w, input logic [31:0] a,
                               input logic [31:0] d);
            tw[p][k] = w;
            ta[p][k] = a;
            td[p][k] = d;
        endtask

        task automatic rand_txn(input int p, input int k);
            set_txn(p, k, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
        endtask

        task automatic drive_port(input int p, input int n);
            for (int k = 0; k < n; k++) begin
                int w;
                req[p]   = 1'b1;
                we[p]    = tw[p][k];
                addr[p]  = ta[p][k];
                wdata[p] = td[p][k];
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!ack[p] && w < 64);
                if (!ack[p]) chk("ack_timeout", 32'(ack[p]), 32'd1);
                @(posedge clk);
                #1;
            end
            req[p] = 1'b0;
        endtask

        // Reference: per round, grants alternate on ties, each transaction starts the cycle
        // after the previous ack, writes take 2 cycles to ack and reads RL+1.
        task automatic run_round(input int n0, input int n1);
            int   idx [2];
            int   t;
            bit   p;
            txn_t e;
            @(posedge clk);
            #1;
            t      = cyc;
            idx[0] = 0;
            idx[1] = 0;
            while (idx[0] < n0 || idx[1] < n1) begin
                if (idx[0] < n0 && idx[1] < n1) p = !lg;
                else p = (idx[0] < n0) ? 1'b0 : 1'b1;
                e.port  = p;
                e.we    = tw[p][idx[p]];
                e.addr  = ta[p][idx[p]];
                e.wdata = e.we ? td[p][idx[p]] : 32'd0;
                e.rdata = e.we ? 32'd0 : ref_mem[e.addr[3:0]];
                if (e.we) ref_mem[e.addr[3:0]] = e.wdata;
                e.cyc = t + (e.we ? 2 : int'(RL) + 1);
                exp_q.push_back(e);
                t  = e.cyc + 1;
                lg = p;
                idx[p]++;
            end
            fork
                drive_port(0, n0);
                drive_port(1, n1);
            join
            @(negedge clk);
            chk("busy_idle", 32'(busy), 32'd0);
            chk("queue_drained", exp_q.size(), 32'd0);
        endtask

        task automatic do_reset();
            rst_n = 1'b0;
            req   = 2'b00;
            #1;
            chk("rst_ack", 32'(ack), 32'd0);
            chk("rst_rdata0", rdata[0], 32'd0);
            chk("rst_rdata1", rdata[1], 32'd0);
            chk("rst_mem_address", mem_addr, 32'd0);
            chk("rst_mem_write_data", mem_wdata, 32'd0);
            chk("rst_mem_strobes", {30'd0, mem_wr, mem_rd}, 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_gnt", 32'(gnt), 32'd0);
            lg         = 1'b1;
            last_rd[0] = 32'd0;
            last_rd[1] = 32'd0;
            exp_q.delete();
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
        endtask

        task automatic reset_mid_read();
            @(posedge clk);
            #1;
            req[0]       = 1'b1;
            we[0]        = 1'b0;
            addr[0]      = 32'd5;
            wdata[0]     = 32'h1234_5678;
            allow_orphan = 1'b1;
            repeat ((RL > 1) ? 2 : 1) @(posedge clk);
            #1;
            chk("pre_reset_memread", 32'(mem_rd), 32'd1);
            #1;
            rst_n = 1'b0;
            #1;
            chk("abort_memread", 32'(mem_rd), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_ack", 32'(ack), 32'd0);
            req[0]     = 1'b0;
            lg         = 1'b1;
            last_rd[0] = 32'd0;
            last_rd[1] = 32'd0;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            repeat (2) begin
                @(negedge clk);
                chk("idle_after_reset", 32'(busy), 32'd0);
                chk("no_ack_after_reset", 32'(ack), 32'd0);
            end
            allow_orphan = 1'b0;
        endtask

        initial begin
            int n0;
            int n1;
            req          = 2'b00;
            we           = 2'b00;
            addr[0]      = '0;
            addr[1]      = '0;
            wdata[0]     = '0;
            wdata[1]     = '0;
            last_rd[0]   = '0;
            last_rd[1]   = '0;
            lg           = 1'b1;
            allow_orphan = 1'b0;
            acc_cnt      = 0;
            #2;
            do_reset();
            set_txn(0, 0, 1'b1, 32'd0, 32'd11);
            run_round(1, 0);
            set_txn(1, 0, 1'b0, 32'd0, 32'd0);
            run_round(0, 1);
            do_reset();
            set_txn(0, 0, 1'b1, 32'd1, 32'hA5);
            set_txn(1, 0, 1'b0, 32'd1, 32'd0);
            run_round(1, 1);
            for (int k = 0; k < 3; k++) begin
                rand_txn(0, k);
                rand_txn(1, k);
            end
            run_round(3, 3);
            reset_mid_read();
            set_txn(0, 0, 1'b0, 32'd5, 32'd0);
            run_round(1, 0);
            set_txn(1, 0, 1'b1, 32'd7, 32'hCAFE_F00D);
            set_txn(0, 0, 1'b0, 32'd7, 32'd0);
            run_round(1, 1);
            repeat (20) begin
                n0 = $urandom_range(0, 3);
                n1 = $urandom_range(0, 3);
                if (n0 == 0 && n1 == 0) n0 = 1;
                for (int k = 0; k < 4; k++) begin
                    rand_txn(0, k);
                    rand_txn(1, k);
                end
                run_round(n0, n1);
            end
            done[g] = 1'b1;
        end
    end

    initial begin
        int i;
        i = 0;
        while (!(done[0] && done[1]) && i < 60000) begin
            @(posedge clk);
            i++;
        end
        chk("run_completed", 32'(done[0] && done[1]), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
